// File: rtl/aes_round_control_unit.sv
// Round sequencer for the AES datapath: ready/valid start, key-length-aware round count,
// multi-cycle round slots, and a result-valid hold until downstream accepts.
module aes_round_control_unit #(
    parameter int DP_LAT = 1,
    parameter int RND_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [1:0]       i_key_len,
    input  logic             i_abort,
    input  logic             i_out_ready,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_dp_en,
    output logic             o_init,
    output logic             o_last,
    output logic [RND_W-1:0] o_round,
    output logic             o_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [1:0] SLOT_LAST = 2'(DP_LAT - 1);

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [RND_W-1:0] nr_q, nr_d;
    logic             slot_end;

    // Reserved key length falls back to AES-128.
    function automatic logic [RND_W-1:0] rounds_for(input logic [1:0] key_len);
        case (key_len)
            2'b01:   return RND_W'(12);
            2'b10:   return RND_W'(14);
            default: return RND_W'(10);
        endcase
    endfunction

    assign slot_end = (slot_q == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= 2'd0;
            round_q <= '0;
            nr_q    <= RND_W'(10);
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            round_q <= round_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        round_d = round_q;
        nr_d    = nr_q;
        case (state_q)
            S_IDLE: begin
                if (i_en && !i_abort) begin
                    nr_d    = rounds_for(i_key_len);
                    round_d = '0;
                    slot_d  = 2'd0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                if (slot_end) begin
                    slot_d  = 2'd0;
                    round_d = RND_W'(1);
                    state_d = S_ROUND;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            S_ROUND: begin
                if (slot_end) begin
                    slot_d  = 2'd0;
                    round_d = round_q + RND_W'(1);
                    if (round_q == nr_q - RND_W'(1)) begin
                        state_d = S_FINAL;
                    end
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            S_FINAL: begin
                if (slot_end) begin
                    slot_d  = 2'd0;
                    state_d = S_DONE;
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    round_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                slot_d  = 2'd0;
                round_d = '0;
            end
        endcase
        // Abort wins over every other transition, including a DONE handshake.
        if (i_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            slot_d  = 2'd0;
            round_d = '0;
        end
    end

    assign o_ready = (state_q == S_IDLE);
    assign o_busy  = (state_q != S_IDLE);
    assign o_dp_en = slot_end &&
                     (state_q == S_INIT || state_q == S_ROUND || state_q == S_FINAL);
    assign o_init  = (state_q == S_INIT);
    assign o_last  = (state_q == S_FINAL);
    assign o_round = round_q;
    assign o_valid = (state_q == S_DONE);

endmodule

// File: tb/tb_aes_round_control_unit.sv
// Bench for aes_round_control_unit: DP_LAT=1 instance driven from a vector table,
// DP_LAT=2 instance driven by a hand-written sequence; datapath strobes go through a scoreboard.
module tb_aes_round_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en1, abort1, ordy1;
    logic [1:0] key1;
    logic       o_ready1, o_busy1, o_dp_en1, o_init1, o_last1, o_valid1;
    logic [3:0] o_round1;
    logic       en2, abort2, ordy2;
    logic [1:0] key2;
    logic       o_ready2, o_busy2, o_dp_en2, o_init2, o_last2, o_valid2;
    logic [3:0] o_round2;

    aes_round_control_unit #(.DP_LAT(1), .RND_W(4)) dut1 (
        .clk(clk), .rst(rst), .i_en(en1), .i_key_len(key1), .i_abort(abort1),
        .i_out_ready(ordy1), .o_ready(o_ready1), .o_busy(o_busy1), .o_dp_en(o_dp_en1),
        .o_init(o_init1), .o_last(o_last1), .o_round(o_round1), .o_valid(o_valid1)
    );

    aes_round_control_unit #(.DP_LAT(2), .RND_W(4)) dut2 (
        .clk(clk), .rst(rst), .i_en(en2), .i_key_len(key2), .i_abort(abort2),
        .i_out_ready(ordy2), .o_ready(o_ready2), .o_busy(o_busy2), .o_dp_en(o_dp_en2),
        .o_init(o_init2), .o_last(o_last2), .o_round(o_round2), .o_valid(o_valid2)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Scoreboard: one entry per expected datapath strobe.
    typedef struct packed {
        logic [3:0] rnd;
        logic       init;
        logic       last;
    } ev_t;

    ev_t q1[$];
    ev_t q2[$];
    ev_t e1, e2;

    task automatic push1(input int nr, input int upto);
        for (int r = 0; r <= upto; r++) q1.push_back('{rnd: 4'(r), init: (r == 0), last: (r == nr)});
    endtask

    task automatic push2(input int nr, input int upto);
        for (int r = 0; r <= upto; r++) q2.push_back('{rnd: 4'(r), init: (r == 0), last: (r == nr)});
    endtask

    always @(negedge clk) begin
        if (o_dp_en1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dp1_unexpected", 1, 0);
            end else begin
                e1 = q1.pop_front();
                chk("dp1_round", 32'(o_round1), 32'(e1.rnd));
                chk("dp1_init", 32'(o_init1), 32'(e1.init));
                chk("dp1_last", 32'(o_last1), 32'(e1.last));
            end
        end
        if (o_dp_en2 === 1'b1) begin
            if (q2.size() == 0) begin
                chk("dp2_unexpected", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("dp2_round", 32'(o_round2), 32'(e2.rnd));
                chk("dp2_init", 32'(o_init2), 32'(e2.init));
                chk("dp2_last", 32'(o_last2), 32'(e2.last));
            end
        end
    end

    task automatic chk_idle1(input string tag);
        chk({tag, "_ready"}, 32'(o_ready1), 1);
        chk({tag, "_busy"}, 32'(o_busy1), 0);
        chk({tag, "_dp_en"}, 32'(o_dp_en1), 0);
        chk({tag, "_init"}, 32'(o_init1), 0);
        chk({tag, "_last"}, 32'(o_last1), 0);
        chk({tag, "_valid"}, 32'(o_valid1), 0);
        chk({tag, "_round"}, 32'(o_round1), 0);
    endtask

    // Starts from a negedge with the DUT idle; i_en stays high while busy to show it is ignored.
    task automatic run1(input logic [1:0] key, input int hold, input int nr, input int lat);
        int  first_valid, valid_cnt, dp_cnt, first_dp, last_dp, ready_m;
        bit  stable;
        push1(nr, nr);
        en1   = 1'b1;
        key1  = key;
        ordy1 = (hold == 0);
        @(posedge clk);
        first_valid = -1; valid_cnt = 0; dp_cnt = 0;
        first_dp = -1; last_dp = -1; ready_m = -1; stable = 1'b1;
        for (int m = 1; m <= 300; m++) begin
            @(negedge clk);
            key1 = 2'($urandom_range(0, 3));
            if (m == 1) begin
                chk("busy_after_accept", 32'(o_busy1), 1);
                chk("ready_low_after_accept", 32'(o_ready1), 0);
            end
            if (o_dp_en1) begin
                dp_cnt++;
                if (first_dp < 0) first_dp = m;
                last_dp = m;
            end
            if (o_valid1) begin
                if (first_valid < 0) first_valid = m;
                valid_cnt++;
                if (o_round1 != 4'(nr)) stable = 1'b0;
                if (valid_cnt > hold) ordy1 = 1'b1;
            end
            if (o_ready1) begin
                ready_m = m;
                break;
            end
        end
        en1   = 1'b0;
        ordy1 = 1'b1;
        if (ready_m < 0) chk("run_timeout", 0, 1);
        chk("latency", first_valid, lat);
        chk("valid_cycles", valid_cnt, hold + 1);
        chk("round_stable_in_done", 32'(stable), 1);
        chk("dp_count", dp_cnt, nr + 1);
        chk("dp_first", first_dp, 1);
        chk("dp_contiguous", last_dp - first_dp + 1, nr + 1);
        chk("ready_return", ready_m, lat + hold + 1);
        chk("idle_busy", 32'(o_busy1), 0);
        chk("idle_round", 32'(o_round1), 0);
        chk("q1_drained", q1.size(), 0);
    endtask

    typedef struct {
        logic [1:0] key;
        int         hold;
        int         nr;
        int         lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit found;
        int dp_cnt2;

        vecs[0] = '{key: 2'b00, hold: 0, nr: 10, lat: 12};
        vecs[1] = '{key: 2'b10, hold: 5, nr: 14, lat: 16};
        vecs[2] = '{key: 2'b01, hold: 0, nr: 12, lat: 14};
        vecs[3] = '{key: 2'b11, hold: 2, nr: 10, lat: 12};
        vecs[4] = '{key: 2'b10, hold: 0, nr: 14, lat: 16};

        rst = 1'b1;
        en1 = 1'b0; abort1 = 1'b0; ordy1 = 1'b1; key1 = 2'b00;
        en2 = 1'b0; abort2 = 1'b0; ordy2 = 1'b1; key2 = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle1("reset");
        chk("reset2_ready", 32'(o_ready2), 1);
        chk("reset2_valid", 32'(o_valid2), 0);
        chk("reset2_dp_en", 32'(o_dp_en2), 0);
        rst = 1'b0;

        // Abort together with start in IDLE: no start.
        en1 = 1'b1; abort1 = 1'b1;
        @(negedge clk);
        chk_idle1("abort_en_idle");
        en1 = 1'b0; abort1 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run1(vecs[i].key, vecs[i].hold, vecs[i].nr, vecs[i].lat);

        // Abort during round 5, then an immediate restart.
        push1(10, 5);
        en1 = 1'b1; key1 = 2'b00;
        @(posedge clk);
        found = 1'b0;
        for (int m = 0; m < 50; m++) begin
            @(negedge clk);
            if (o_round1 == 4'd5) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reached_r5", 32'(found), 1);
        en1 = 1'b0; abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk_idle1("after_abort");
        chk("abort_q_drained", q1.size(), 0);
        run1(2'b00, 0, 10, 12);

        // Reset pulsed in the middle of ROUND.
        push1(10, 4);
        en1 = 1'b1; key1 = 2'b00;
        @(posedge clk);
        found = 1'b0;
        for (int m = 0; m < 50; m++) begin
            @(negedge clk);
            if (o_round1 == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_reached_r4", 32'(found), 1);
        en1 = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk_idle1("mid_run_reset");
        rst = 1'b0;
        chk("rst_q_drained", q1.size(), 0);
        @(negedge clk);

        // DP_LAT=2, AES-192 with key length toggling mid-run.
        push2(12, 12);
        en2 = 1'b1; key2 = 2'b01; ordy2 = 1'b1;
        @(posedge clk);
        dp_cnt2 = 0;
        for (int m = 1; m <= 28; m++) begin
            @(negedge clk);
            key2 = 2'($urandom_range(0, 3));
            if (m <= 26) begin
                chk("dl2_dp_en", 32'(o_dp_en2), 32'(m % 2 == 0));
                chk("dl2_init", 32'(o_init2), 32'(m <= 2));
                chk("dl2_last", 32'(o_last2), 32'(m >= 25));
                chk("dl2_round", 32'(o_round2), 32'((m - 1) / 2));
                chk("dl2_valid_early", 32'(o_valid2), 0);
                if (o_dp_en2) dp_cnt2++;
            end else if (m == 27) begin
                chk("dl2_valid", 32'(o_valid2), 1);
                chk("dl2_done_round", 32'(o_round2), 12);
                en2 = 1'b0;
            end else begin
                chk("dl2_ready_after", 32'(o_ready2), 1);
                chk("dl2_valid_after", 32'(o_valid2), 0);
            end
        end
        chk("dl2_dp_count", dp_cnt2, 13);
        chk("q2_drained", q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/aes_round_control_unit.md
# aes_round_control_unit

Parametrised, key-length-aware sequencer for the AES round datapath. It is the next-generation control unit. It accepts a start request through a ready/valid handshake and latches the key length (128/192/256 → 10/12/14 rounds). It then steps the datapath through the initial AddRoundKey, the middle rounds and the final round, supporting multi-cycle round slots, and holds the result valid until downstream accepts it. It sits between the GCM top-level controller and the AES round/key-schedule datapath.

## Interface
- DP_LAT, 1, cycles per round slot (legal 1..4)
- RND_W, 4, width of round index output (≥4)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- i_en  input  1  start request; accepted when i_en && o_ready
- i_key_len  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved (treated as 00); sampled only on accept
- i_abort  input  1  cancel current operation
- i_out_ready  input  1  downstream accepts result
- o_ready  output  1  idle, can accept start
- o_busy  output  1  operation in progress (INIT/ROUND/FINAL/DONE)
- o_dp_en  output  1  datapath state-register load strobe
- o_init  output  1  current slot is initial AddRoundKey (round 0)
- o_last  output  1  current slot is final round (skip MixColumns)
- o_round  output  RND_W  current round index 0..Nr
- o_valid  output  1  result valid, held until i_out_ready

## Operation
- States: IDLE, INIT, ROUND, FINAL, DONE.
- Nr is latched at accept: 10, 12 or 14. The latched value is unaffected by later i_key_len changes.
- IDLE: o_ready=1. On i_en, latch Nr and clear the round counter. Next state is INIT.
- INIT: one slot, o_round=0, o_init=1. At the end of the slot → ROUND with o_round=1.
- ROUND: one slot per round, covering rounds 1..Nr-1. o_round increments at each slot end. After round Nr-1 completes → FINAL.
- FINAL: one slot, o_round=Nr, o_last=1. At the end of the slot → DONE.
- DONE: o_valid=1, o_round holds Nr. Goes to IDLE on i_out_ready.
- Slot: DP_LAT cycles, tracked by a slot counter (0..DP_LAT-1). o_dp_en=1 only on the last cycle of each slot. With DP_LAT=1, o_dp_en is continuously high from INIT through FINAL.
- o_init and o_last are high for the whole slot. o_dp_en count per operation is exactly Nr+1.
- i_en while not in IDLE is ignored; no queuing.
- i_abort in any non-IDLE state goes to IDLE on the next edge. In that case o_valid does not assert, counters clear, and o_dp_en is 0 from that edge.
- i_abort and i_out_ready together in DONE: go to IDLE; the result counts as delivered.
- i_abort in IDLE is ignored. i_abort and i_en together in IDLE: abort wins and the start is not accepted.
- rst asserted in any state: IDLE on next edge, all counters cleared. rst overrides all inputs.

## Timing
- Reset values after the rst edge: o_ready=1; o_busy, o_dp_en, o_init, o_last, o_valid=0; o_round=0.
- All outputs decode registered state. There is no combinational input→output path.
- Accept at edge E0. INIT occupies cycles E0+1..E0+DP_LAT.
- Latency: o_valid rises (Nr+1)*DP_LAT+1 cycles after E0:
  - AES-128, DP_LAT=1: 12 cycles.
  - AES-256, DP_LAT=1: 16 cycles.
  - AES-192, DP_LAT=2: 27 cycles.
- o_busy rises the cycle after E0 and falls the cycle after the DONE handshake or abort.
- o_ready is 0 from E0+1 until return to IDLE.
- A new start can be accepted at the earliest 1 cycle after the DONE→IDLE transition. Minimum initiation interval is (Nr+1)*DP_LAT+2 cycles with i_out_ready held high.
- Round counter is RND_W bits and never exceeds 14; no wrap.

## Test plan
- Reset, then i_en=1, i_key_len=00, DP_LAT=1, i_out_ready=1:
  - o_dp_en high for exactly 11 consecutive cycles.
  - o_round sequence is 0,1..10, with o_init on 0 and o_last on 10.
  - o_valid rises 12 cycles after accept, lasts 1 cycle, then o_ready=1.
- i_key_len=10, i_out_ready=0 for 5 cycles after o_valid:
  - 15 o_dp_en pulses, o_last at round 14.
  - o_valid held 6 cycles with o_round=14 stable, then IDLE.
- DP_LAT=2, i_key_len=01: o_dp_en pulses every other cycle (13 pulses), o_valid at accept+27. Toggling i_key_len mid-run changes nothing.
- i_abort at round 5 (AES-128): IDLE next cycle, o_valid never asserts, and a new start accepted next cycle runs a full 10-round sequence.
- rst pulsed in ROUND: all outputs at reset values after the edge. i_en during busy, and i_en with i_abort in IDLE, both produce no start.
